// File: rtl/gaussian_row_fetch_if.sv
// Handshake/bus bundle between gaussian_row_fetch and its SRAM, line buffer
// and frame controller. The slave modport is the fetch block itself.
interface gaussian_row_fetch_if #(
   parameter int ADDR_W = 10
);
   logic              start;
   logic              abort;
   logic [ADDR_W-1:0] base_addr;
   logic              sram_re;
   logic [ADDR_W-1:0] sram_addr;
   logic [5119:0]     sram_rdata;
   logic [2:0]        buffer_mode;
   logic              buffer_we;
   logic [5119:0]     img_data;
   logic              busy;
   logic              done;

   modport master (
      output start, abort, base_addr, sram_rdata,
      input  sram_re, sram_addr, buffer_mode, buffer_we,
      input  img_data, busy, done
   );

   modport slave (
      input  start, abort, base_addr, sram_rdata,
      output sram_re, sram_addr, buffer_mode, buffer_we,
      output img_data, busy, done
   );
endinterface

// File: rtl/gaussian_row_fetch.sv
// Row sequencer feeding the Gaussian line buffer from SRAM.
// Optional top padding: define GAUSSIAN_ROW_FETCH_PAD_TOP_EN.
module gaussian_row_fetch #(
   parameter int IMG_ROWS   = 480,
   parameter int ADDR_W     = 10,
   parameter int SRAM_LAT   = 1,
   parameter int FLUSH_ROWS = 5
) (
   input logic                 clk,
   input logic                 rst,
   gaussian_row_fetch_if.slave bus
);
   localparam int ROW_W = $clog2(IMG_ROWS + 1);
   localparam int FL_W  = $clog2(FLUSH_ROWS + 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_ROWS);
   localparam logic [FL_W-1:0]  FL_LAST  = FL_W'(FLUSH_ROWS);
   localparam logic [2:0] SYS_IDLE     = 3'd0;
   localparam logic [2:0] SYS_GAUSSIAN = 3'd1;

`ifdef GAUSSIAN_ROW_FETCH_PAD_TOP_EN
   typedef enum logic [2:0] {
      S_IDLE, S_PRIME, S_PAD, S_FETCH, S_DRAIN, S_FLUSH, S_DONE
   } state_t;
`else
   typedef enum logic [2:0] {
      S_IDLE, S_PRIME, S_FETCH, S_DRAIN, S_FLUSH, S_DONE
   } state_t;
`endif

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [ROW_W-1:0]    rows_q, rows_d;
   logic [FL_W-1:0]     fl_q, fl_d;
   logic [SRAM_LAT-1:0] vld_q, vld_d;
   logic                re_q, re_d;
   logic [2:0]          mode_q, mode_d;
   logic                we_q, we_d;
   logic [5119:0]       data_q, data_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;

   // Next-state and next-output logic for the frame sequencer.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      rows_d  = rows_q;
      fl_d    = fl_q;
      re_d    = 1'b0;
      mode_d  = mode_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      vld_d[0] = re_q;
      for (int i = 1; i < SRAM_LAT; i++) begin
         vld_d[i] = vld_q[i-1];
      end
      we_d   = vld_q[SRAM_LAT-1];
      data_d = vld_q[SRAM_LAT-1] ? bus.sram_rdata : data_q;

      unique case (state_q)
         S_IDLE: begin
            if (bus.start && !bus.abort) begin
               state_d = S_PRIME;
               addr_d  = bus.base_addr;
               mode_d  = SYS_GAUSSIAN;
               busy_d  = 1'b1;
            end
         end
         S_PRIME: begin
`ifdef GAUSSIAN_ROW_FETCH_PAD_TOP_EN
            state_d = S_PAD;
            fl_d    = FL_W'(1);
`else
            state_d = S_FETCH;
            re_d    = 1'b1;
            rows_d  = ROW_W'(1);
`endif
         end
`ifdef GAUSSIAN_ROW_FETCH_PAD_TOP_EN
         S_PAD: begin
            if (fl_q == FL_LAST) begin
               state_d = S_FETCH;
               re_d    = 1'b1;
               rows_d  = ROW_W'(1);
            end else begin
               fl_d = fl_q + FL_W'(1);
            end
         end
`endif
         S_FETCH: begin
            if (rows_q == ROW_LAST) begin
               state_d = S_DRAIN;
            end else begin
               re_d   = 1'b1;
               addr_d = addr_q + ADDR_W'(1);
               rows_d = rows_q + ROW_W'(1);
            end
         end
         S_DRAIN: begin
            if (vld_q == '0) begin
               state_d = S_FLUSH;
               fl_d    = FL_W'(1);
            end
         end
         S_FLUSH: begin
            if (fl_q == FL_LAST) begin
               state_d = S_DONE;
               mode_d  = SYS_IDLE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end else begin
               fl_d = fl_q + FL_W'(1);
            end
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      if (bus.abort && state_q != S_IDLE) begin
         state_d = S_IDLE;
         mode_d  = SYS_IDLE;
         re_d    = 1'b0;
         we_d    = 1'b0;
         busy_d  = 1'b0;
         done_d  = 1'b0;
         vld_d   = '0;
         data_d  = data_q;
      end
   end

   // State and registered outputs, synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         rows_q  <= '0;
         fl_q    <= '0;
         vld_q   <= '0;
         re_q    <= 1'b0;
         mode_q  <= SYS_IDLE;
         we_q    <= 1'b0;
         data_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         rows_q  <= rows_d;
         fl_q    <= fl_d;
         vld_q   <= vld_d;
         re_q    <= re_d;
         mode_q  <= mode_d;
         we_q    <= we_d;
         data_q  <= data_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign bus.sram_re     = re_q;
   assign bus.sram_addr   = addr_q;
   assign bus.buffer_mode = mode_q;
   assign bus.buffer_we   = we_q;
   assign bus.img_data    = data_q;
   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
endmodule

// File: tb/tb_gaussian_row_fetch.sv
// Bench for gaussian_row_fetch: SRAM_LAT=1 and SRAM_LAT=3 instances
// driven in lockstep, checked against a cycle-offset frame model.
module tb_gaussian_row_fetch;
   localparam int N  = 4;
   localparam int F  = 5;
   localparam int AW = 10;
`ifdef GAUSSIAN_ROW_FETCH_PAD_TOP_EN
   localparam int P = F;
`else
   localparam int P = 0;
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   gaussian_row_fetch_if #(.ADDR_W(AW)) if0 ();
   gaussian_row_fetch_if #(.ADDR_W(AW)) if1 ();

   gaussian_row_fetch #(
      .IMG_ROWS(N), .ADDR_W(AW), .SRAM_LAT(1), .FLUSH_ROWS(F)
   ) u_dut1 (.clk(clk), .rst(rst), .bus(if0));

   gaussian_row_fetch #(
      .IMG_ROWS(N), .ADDR_W(AW), .SRAM_LAT(3), .FLUSH_ROWS(F)
   ) u_dut3 (.clk(clk), .rst(rst), .bus(if1));

   logic [31:0] seed;
   int n_chk = 0;
   int n_err = 0;
   int cyc = 0;

   function automatic logic [5119:0] row(input logic [AW-1:0] a);
      logic [31:0] h;
      h = (32'(a) * 32'h9E3779B1) ^ seed;
      return {160{h}};
   endfunction

   // SRAM models: data valid exactly LAT cycles after the read cycle,
   // garbage otherwise.
   always @(posedge clk) begin : sram1
      logic [31:0] g;
      g = $urandom;
      if (if0.sram_re === 1'b1) if0.sram_rdata <= row(if0.sram_addr);
      else if0.sram_rdata <= {160{g}};
   end

   logic          re_p1, re_p2;
   logic [AW-1:0] ad_p1, ad_p2;
   always @(posedge clk) begin : sram3
      logic [31:0] g;
      g = $urandom;
      re_p1 <= (if1.sram_re === 1'b1);
      ad_p1 <= if1.sram_addr;
      re_p2 <= re_p1;
      ad_p2 <= ad_p1;
      if (re_p2) if1.sram_rdata <= row(ad_p2);
      else if1.sram_rdata <= {160{g}};
   end

   // Reference model: per instance, frame offset k since accepted start.
   int            act[2];
   int            kk[2];
   logic [AW-1:0] mbase[2];
   logic [5119:0] last[2];
   int            nd_exp[2];
   int            nd_obs[2];

   function automatic int lat_of(input int d);
      return (d == 0) ? 1 : 3;
   endfunction

   function automatic int kdone(input int d);
      return 3 + P + N + lat_of(d) + F;
   endfunction

   task automatic chk(input string tag, input int d,
                      input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s dut%0d cyc=%0d observed=%0h expected=%0h",
                tag, d, cyc, obs, exp);
      end
   endtask

   task automatic chk_data(input int d, input logic [5119:0] obs,
                           input logic [5119:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL img_data dut%0d cyc=%0d observed[31:0]=%0h expected[31:0]=%0h",
                d, cyc, obs[31:0], exp[31:0]);
      end
   endtask

   task automatic check_dut(input int d, input logic [2:0] mode,
                            input logic re, input logic [AW-1:0] addr,
                            input logic we, input logic [5119:0] data,
                            input logic busy, input logic done);
      int  k, kd, l;
      bit  on, e_re, e_we;
      k  = kk[d];
      kd = kdone(d);
      l  = lat_of(d);
      on = (act[d] != 0) && k <= kd;
      e_re = on && k >= 2 + P && k <= 1 + P + N;
      e_we = on && k >= 3 + P + l && k <= 2 + P + N + l;
      if (e_we) last[d] = row(mbase[d] + AW'(k - 3 - P - l));
      chk("buffer_mode", d, 64'(mode), (on && k < kd) ? 64'd1 : 64'd0);
      chk("busy", d, 64'(busy), (on && k < kd) ? 64'd1 : 64'd0);
      chk("done", d, 64'(done), (on && k == kd) ? 64'd1 : 64'd0);
      chk("sram_re", d, 64'(re), e_re ? 64'd1 : 64'd0);
      if (e_re) chk("sram_addr", d, 64'(addr),
                    64'(AW'(mbase[d] + AW'(k - 2 - P))));
      chk("buffer_we", d, 64'(we), e_we ? 64'd1 : 64'd0);
      chk_data(d, data, last[d]);
      if (on && k == kd) nd_exp[d]++;
   endtask

   task automatic update(input int d, input logic s, input logic a,
                         input logic r, input logic [AW-1:0] b);
      int kd;
      kd = kdone(d);
      if (r) begin
         act[d]  = 0;
         last[d] = '0;
      end else if (act[d] != 0 && kk[d] <= kd && a) begin
         act[d] = 0;
      end else if ((act[d] == 0 || kk[d] > kd) && s && !a) begin
         act[d]   = 1;
         kk[d]    = 1;
         mbase[d] = b;
      end else if (act[d] != 0) begin
         kk[d]++;
      end
   endtask

   task automatic step(input logic s, input logic a, input logic r,
                       input logic [AW-1:0] b, input bit en = 1'b1);
      rst           = r;
      if0.start     = s;
      if1.start     = s;
      if0.abort     = a;
      if1.abort     = a;
      if0.base_addr = b;
      if1.base_addr = b;
      @(negedge clk);
      if (en) begin
         check_dut(0, if0.buffer_mode, if0.sram_re, if0.sram_addr,
                   if0.buffer_we, if0.img_data, if0.busy, if0.done);
         check_dut(1, if1.buffer_mode, if1.sram_re, if1.sram_addr,
                   if1.buffer_we, if1.img_data, if1.busy, if1.done);
      end
      if (if0.done === 1'b1) nd_obs[0]++;
      if (if1.done === 1'b1) nd_obs[1]++;
      update(0, s, a, r, b);
      update(1, s, a, r, b);
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, AW'($urandom));
   endtask

   initial begin
      int d0, d1;
      seed = $urandom;
      for (int d = 0; d < 2; d++) begin
         act[d] = 0; kk[d] = 0; mbase[d] = '0; last[d] = '0;
         nd_exp[d] = 0; nd_obs[d] = 0;
      end

      step(1'b0, 1'b0, 1'b1, '0, 1'b0);
      step(1'b0, 1'b0, 1'b1, '0, 1'b0);
      idle(2);

      // Basic frame at base 0x10.
      step(1'b1, 1'b0, 1'b0, AW'(10'h010));
      idle(24);

      // Address wrap.
      step(1'b1, 1'b0, 1'b0, AW'(10'h3FE));
      idle(24);

      // Abort in the second FETCH cycle, then a fresh frame.
      step(1'b1, 1'b0, 1'b0, AW'($urandom));
      idle(2 + P);
      step(1'b0, 1'b1, 1'b0, AW'($urandom));
      idle(1);
      step(1'b1, 1'b0, 1'b0, AW'($urandom));
      idle(24);

      // start pulses during FETCH and FLUSH are ignored.
      d0 = nd_obs[0];
      d1 = nd_obs[1];
      step(1'b1, 1'b0, 1'b0, AW'($urandom));
      idle(2 + P);
      step(1'b1, 1'b0, 1'b0, AW'($urandom));
      idle(7);
      step(1'b1, 1'b0, 1'b0, AW'($urandom));
      idle(12);
      chk("one_done", 0, 64'(nd_obs[0] - d0), 64'd1);
      chk("one_done", 1, 64'(nd_obs[1] - d1), 64'd1);

      // Reset in the middle of FLUSH.
      step(1'b1, 1'b0, 1'b0, AW'($urandom));
      idle(10 + P);
      step(1'b0, 1'b0, 1'b1, AW'($urandom));
      idle(3);

      // Random start/abort/reset traffic.
      for (int i = 0; i < 400; i++) begin
         step(($urandom % 8) == 0, ($urandom % 40) == 0,
              ($urandom % 150) == 0, AW'($urandom));
      end
      idle(30);

      chk("done_count", 0, 64'(nd_obs[0]), 64'(nd_exp[0]));
      chk("done_count", 1, 64'(nd_obs[1]), 64'(nd_exp[1]));

      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
      $finish;
   end
endmodule
